// File: rtl/pwm_regs_pkg.sv
// Shared offsets, parameter limits and byte helpers for the PWM register block.
package pwm_regs_pkg;

    localparam int unsigned NUM_CH_MIN   = 1;
    localparam int unsigned NUM_CH_MAX   = 4;
    localparam int unsigned CNT_W_NARROW = 8;
    localparam int unsigned CNT_W_WIDE   = 16;
    localparam int unsigned BYTE_W       = 8;

    localparam logic [3:0] OFF_PER_LO = 4'h0;
    localparam logic [3:0] OFF_PER_HI = 4'h1;
    localparam logic [3:0] OFF_EN     = 4'h2;
    localparam logic [3:0] OFF_C1_LO  = 4'h3;
    localparam logic [3:0] OFF_C1_HI  = 4'h4;
    localparam logic [3:0] OFF_C2_LO  = 4'h5;
    localparam logic [3:0] OFF_C2_HI  = 4'h6;
    localparam logic [3:0] OFF_CNT_RST = 4'h7;
    localparam logic [3:0] OFF_CNT_LO = 4'h8;
    localparam logic [3:0] OFF_CNT_HI = 4'h9;
    localparam logic [3:0] OFF_PRESC  = 4'hA;
    localparam logic [3:0] OFF_UPD    = 4'hB;
    localparam logic [3:0] OFF_PWM_EN = 4'hC;
    localparam logic [3:0] OFF_FUNC   = 4'hD;
    localparam logic [3:0] OFF_STATUS = 4'hE;
    localparam logic [3:0] OFF_COMMIT = 4'hF;

    // Values are widened to 16 bits so narrow counters simply lose the hi byte.
    function automatic logic [15:0] put_byte(input logic [15:0] v, input logic hi,
                                             input logic [7:0] b);
        logic [15:0] r;
        r = v;
        if (hi) r[15:8] = b;
        else    r[7:0]  = b;
        return r;
    endfunction

    function automatic logic [7:0] hi_byte(input logic [15:0] v);
        return v[15:8];
    endfunction

endpackage

// File: rtl/pwm_ch_regs.sv
// One PWM channel's register set: shadow/active copies, commit, count_reset pulse,
// counter snapshot and sticky period status.
module pwm_ch_regs
    import pwm_regs_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic [3:0]        off_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic              period_done_i,
    output logic [BYTE_W-1:0] rdata_c,
    output logic [CNT_W-1:0]  period_o,
    output logic [CNT_W-1:0]  cmp1_o,
    output logic [CNT_W-1:0]  cmp2_o,
    output logic              en_o,
    output logic              count_reset_o,
    output logic              upnotdown_o,
    output logic              pwm_en_o,
    output logic [BYTE_W-1:0] prescale_o,
    output logic [BYTE_W-1:0] functions_o
);

    logic [CNT_W-1:0]  per_sh_q, per_sh_d, per_act_q, per_act_d;
    logic [CNT_W-1:0]  c1_sh_q, c1_sh_d, c1_act_q, c1_act_d;
    logic [CNT_W-1:0]  c2_sh_q, c2_sh_d, c2_act_q, c2_act_d;
    logic [BYTE_W-1:0] fn_sh_q, fn_sh_d, fn_act_q, fn_act_d;
    logic [BYTE_W-1:0] presc_q, presc_d, snap_q, snap_d;
    logic              en_q, en_d, upd_q, upd_d, pwm_q, pwm_d;
    logic              cr_q, cr_d, cr_hold_q, cr_hold_d;
    logic              status_q, status_d, pend_q, pend_d;
    logic              xfer_c;

    // Next-state: transfer uses pre-write shadows, writes land afterwards.
    always_comb begin
        per_sh_d  = per_sh_q;  per_act_d = per_act_q;
        c1_sh_d   = c1_sh_q;   c1_act_d  = c1_act_q;
        c2_sh_d   = c2_sh_q;   c2_act_d  = c2_act_q;
        fn_sh_d   = fn_sh_q;   fn_act_d  = fn_act_q;
        presc_d   = presc_q;   snap_d    = snap_q;
        en_d      = en_q;      upd_d     = upd_q;     pwm_d = pwm_q;
        cr_d      = cr_q;      cr_hold_d = cr_hold_q;
        status_d  = status_q;  pend_d    = pend_q;

        xfer_c = pend_q && (period_done_i || !en_q);
        if (xfer_c) begin
            per_act_d = per_sh_q;
            c1_act_d  = c1_sh_q;
            c2_act_d  = c2_sh_q;
            fn_act_d  = fn_sh_q;
            pend_d    = 1'b0;
        end

        // count_reset holds for a second cycle, then drops
        if (cr_hold_q) cr_hold_d = 1'b0;
        else           cr_d      = 1'b0;

        if (rd_i && off_i == OFF_CNT_LO) snap_d = hi_byte(16'(cnt_i));

        if (wr_i) begin
            case (off_i)
                OFF_PER_LO, OFF_PER_HI:
                    per_sh_d = CNT_W'(put_byte(16'(per_sh_q), off_i == OFF_PER_HI, wdata_i));
                OFF_C1_LO, OFF_C1_HI:
                    c1_sh_d = CNT_W'(put_byte(16'(c1_sh_q), off_i == OFF_C1_HI, wdata_i));
                OFF_C2_LO, OFF_C2_HI:
                    c2_sh_d = CNT_W'(put_byte(16'(c2_sh_q), off_i == OFF_C2_HI, wdata_i));
                OFF_EN:      en_d    = wdata_i[0];
                OFF_CNT_RST: begin
                    cr_d      = wdata_i[0];
                    cr_hold_d = wdata_i[0];
                end
                OFF_PRESC:   presc_d = wdata_i;
                OFF_UPD:     upd_d   = wdata_i[0];
                OFF_PWM_EN:  pwm_d   = wdata_i[0];
                OFF_FUNC:    fn_sh_d = wdata_i;
                OFF_STATUS:  if (wdata_i[0]) status_d = 1'b0;
                OFF_COMMIT:  if (wdata_i[0]) pend_d   = 1'b1;
                default: ;
            endcase
        end

        if (period_done_i) status_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_sh_q <= '0;  per_act_q <= '0;
            c1_sh_q  <= '0;  c1_act_q  <= '0;
            c2_sh_q  <= '0;  c2_act_q  <= '0;
            fn_sh_q  <= '0;  fn_act_q  <= '0;
            presc_q  <= '0;  snap_q    <= '0;
            en_q     <= 1'b0; upd_q    <= 1'b0; pwm_q <= 1'b0;
            cr_q     <= 1'b0; cr_hold_q <= 1'b0;
            status_q <= 1'b0; pend_q   <= 1'b0;
        end else begin
            per_sh_q <= per_sh_d; per_act_q <= per_act_d;
            c1_sh_q  <= c1_sh_d;  c1_act_q  <= c1_act_d;
            c2_sh_q  <= c2_sh_d;  c2_act_q  <= c2_act_d;
            fn_sh_q  <= fn_sh_d;  fn_act_q  <= fn_act_d;
            presc_q  <= presc_d;  snap_q    <= snap_d;
            en_q     <= en_d;     upd_q     <= upd_d;  pwm_q <= pwm_d;
            cr_q     <= cr_d;     cr_hold_q <= cr_hold_d;
            status_q <= status_d; pend_q    <= pend_d;
        end
    end

    // Read-back: shadows for shadowed fields, live counter lo, snapshot for hi
    always_comb begin
        rdata_c = '0;
        if (rd_i) begin
            case (off_i)
                OFF_PER_LO: rdata_c = 8'(per_sh_q);
                OFF_PER_HI: rdata_c = hi_byte(16'(per_sh_q));
                OFF_EN:     rdata_c = {7'b0, en_q};
                OFF_C1_LO:  rdata_c = 8'(c1_sh_q);
                OFF_C1_HI:  rdata_c = hi_byte(16'(c1_sh_q));
                OFF_C2_LO:  rdata_c = 8'(c2_sh_q);
                OFF_C2_HI:  rdata_c = hi_byte(16'(c2_sh_q));
                OFF_CNT_LO: rdata_c = 8'(cnt_i);
                OFF_CNT_HI: rdata_c = snap_q;
                OFF_PRESC:  rdata_c = presc_q;
                OFF_UPD:    rdata_c = {7'b0, upd_q};
                OFF_PWM_EN: rdata_c = {7'b0, pwm_q};
                OFF_FUNC:   rdata_c = fn_sh_q;
                OFF_STATUS: rdata_c = {7'b0, status_q};
                OFF_COMMIT: rdata_c = {7'b0, pend_q};
                default:    rdata_c = '0;
            endcase
        end
    end

    assign period_o      = per_act_q;
    assign cmp1_o        = c1_act_q;
    assign cmp2_o        = c2_act_q;
    assign functions_o   = fn_act_q;
    assign prescale_o    = presc_q;
    assign en_o          = en_q;
    assign upnotdown_o   = upd_q;
    assign pwm_en_o      = pwm_q;
    assign count_reset_o = cr_q;

endmodule

// File: rtl/pwm_regs_mc.sv
// Multi-channel PWM register file: channel decode and read mux over pwm_ch_regs.
module pwm_regs_mc
    import pwm_regs_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      read,
    input  logic                      write,
    input  logic [5:0]                addr,
    input  logic [7:0]                data_write,
    output logic [7:0]                data_read,
    input  logic [NUM_CH*CNT_W-1:0]   counter_val,
    input  logic [NUM_CH-1:0]         period_done,
    output logic [NUM_CH*CNT_W-1:0]   period,
    output logic [NUM_CH*CNT_W-1:0]   compare1,
    output logic [NUM_CH*CNT_W-1:0]   compare2,
    output logic [NUM_CH-1:0]         en,
    output logic [NUM_CH-1:0]         count_reset,
    output logic [NUM_CH-1:0]         upnotdown,
    output logic [NUM_CH-1:0]         pwm_en,
    output logic [NUM_CH*8-1:0]       prescale,
    output logic [NUM_CH*8-1:0]       functions
);

    logic [BYTE_W-1:0] ch_rdata [NUM_CH];

    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX ||
        (CNT_W != CNT_W_NARROW && CNT_W != CNT_W_WIDE)) begin : g_bad_param
        $error("pwm_regs_mc: illegal NUM_CH or CNT_W");
    end

    // Channels above NUM_CH have no instance, so they read 0 and ignore writes
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic hit;
        assign hit = (addr[5:4] == 2'(c));

        pwm_ch_regs #(.CNT_W(CNT_W)) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .rd_i          (read && hit),
            .wr_i          (write && hit),
            .off_i         (addr[3:0]),
            .wdata_i       (data_write),
            .cnt_i         (counter_val[c*CNT_W +: CNT_W]),
            .period_done_i (period_done[c]),
            .rdata_c       (ch_rdata[c]),
            .period_o      (period[c*CNT_W +: CNT_W]),
            .cmp1_o        (compare1[c*CNT_W +: CNT_W]),
            .cmp2_o        (compare2[c*CNT_W +: CNT_W]),
            .en_o          (en[c]),
            .count_reset_o (count_reset[c]),
            .upnotdown_o   (upnotdown[c]),
            .pwm_en_o      (pwm_en[c]),
            .prescale_o    (prescale[c*8 +: 8]),
            .functions_o   (functions[c*8 +: 8])
        );
    end

    always_comb begin
        data_read = '0;
        for (int c = 0; c < NUM_CH; c++) data_read |= ch_rdata[c];
    end

endmodule

// File: tb/tb_pwm_regs_mc.sv
// Randomized + directed bench for pwm_regs_mc against a per-channel behavioural model.
module tb_pwm_regs_mc;

    localparam int NCH = 2;
    localparam int CW  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd, wr;
    logic [5:0]  addr;
    logic [7:0]  wd, drd, last_rd;
    logic [31:0] cv, per, c1, c2;
    logic [1:0]  pd, en, cr, upd, pwe;
    logic [15:0] presc, fn;

    logic        rd8, wr8;
    logic [5:0]  addr8;
    logic [7:0]  wd8, drd8, last_rd8;
    logic [15:0] cv8, per8, c18, c28, presc8, fn8;
    logic [1:0]  pd8, en8, cr8, upd8, pwe8;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state, one entry per channel
    int m_per_sh[NCH], m_per_act[NCH], m_c1_sh[NCH], m_c1_act[NCH];
    int m_c2_sh[NCH], m_c2_act[NCH], m_fn_sh[NCH], m_fn_act[NCH];
    int m_en[NCH], m_presc[NCH], m_upd[NCH], m_pwm[NCH];
    int m_cr_left[NCH], m_snap[NCH], m_status[NCH], m_pend[NCH];

    always #5 clk = ~clk;

    pwm_regs_mc #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .read(rd), .write(wr), .addr(addr),
        .data_write(wd), .data_read(drd), .counter_val(cv), .period_done(pd),
        .period(per), .compare1(c1), .compare2(c2), .en(en), .count_reset(cr),
        .upnotdown(upd), .pwm_en(pwe), .prescale(presc), .functions(fn)
    );

    pwm_regs_mc #(.NUM_CH(2), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .read(rd8), .write(wr8), .addr(addr8),
        .data_write(wd8), .data_read(drd8), .counter_val(cv8), .period_done(pd8),
        .period(per8), .compare1(c18), .compare2(c28), .en(en8), .count_reset(cr8),
        .upnotdown(upd8), .pwm_en(pwe8), .prescale(presc8), .functions(fn8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int byte_of(input int v, input int hi);
        return (v >> (8 * hi)) & 255;
    endfunction

    function automatic int set_byte(input int v, input int hi, input int b);
        return hi != 0 ? ((v & 'h00FF) | (b << 8)) : ((v & 'hFF00) | b);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_per_sh[c] = 0; m_per_act[c] = 0; m_c1_sh[c] = 0; m_c1_act[c] = 0;
            m_c2_sh[c] = 0;  m_c2_act[c] = 0;  m_fn_sh[c] = 0; m_fn_act[c] = 0;
            m_en[c] = 0; m_presc[c] = 0; m_upd[c] = 0; m_pwm[c] = 0;
            m_cr_left[c] = 0; m_snap[c] = 0; m_status[c] = 0; m_pend[c] = 0;
        end
    endtask

    function automatic logic [7:0] model_read(input logic r, input logic [5:0] a,
                                              input logic [31:0] cvv);
        int ch, off, cnt;
        ch  = int'(a[5:4]);
        off = int'(a[3:0]);
        if (!r || ch >= NCH) return 8'h00;
        cnt = int'((cvv >> (CW * ch)) & 32'hFFFF);
        case (off)
            0:  return 8'(byte_of(m_per_sh[ch], 0));
            1:  return 8'(byte_of(m_per_sh[ch], 1));
            2:  return 8'(m_en[ch]);
            3:  return 8'(byte_of(m_c1_sh[ch], 0));
            4:  return 8'(byte_of(m_c1_sh[ch], 1));
            5:  return 8'(byte_of(m_c2_sh[ch], 0));
            6:  return 8'(byte_of(m_c2_sh[ch], 1));
            8:  return 8'(cnt & 255);
            9:  return 8'(m_snap[ch]);
            10: return 8'(m_presc[ch]);
            11: return 8'(m_upd[ch]);
            12: return 8'(m_pwm[ch]);
            13: return 8'(m_fn_sh[ch]);
            14: return 8'(m_status[ch]);
            15: return 8'(m_pend[ch]);
            default: return 8'h00;
        endcase
    endfunction

    // Advance the model by one clock edge with the inputs sampled at that edge
    task automatic model_step(input logic r, input logic w, input logic [5:0] a,
                              input logic [7:0] d, input logic [1:0] pdv, input logic [31:0] cvv);
        for (int ch = 0; ch < NCH; ch++) begin
            int off, cnt;
            bit sel, xfer;
            sel  = (int'(a[5:4]) == ch);
            off  = int'(a[3:0]);
            cnt  = int'((cvv >> (CW * ch)) & 32'hFFFF);
            xfer = (m_pend[ch] != 0) && (pdv[ch] == 1'b1 || m_en[ch] == 0);
            if (xfer) begin
                m_per_act[ch] = m_per_sh[ch]; m_c1_act[ch] = m_c1_sh[ch];
                m_c2_act[ch]  = m_c2_sh[ch];  m_fn_act[ch] = m_fn_sh[ch];
                m_pend[ch]    = 0;
            end
            if (m_cr_left[ch] > 0) m_cr_left[ch]--;
            if (r && sel && off == 8) m_snap[ch] = (cnt >> 8) & 255;
            if (w && sel) begin
                case (off)
                    0, 1:  m_per_sh[ch] = set_byte(m_per_sh[ch], off - 0, int'(d));
                    3, 4:  m_c1_sh[ch]  = set_byte(m_c1_sh[ch], off - 3, int'(d));
                    5, 6:  m_c2_sh[ch]  = set_byte(m_c2_sh[ch], off - 5, int'(d));
                    2:     m_en[ch]     = int'(d[0]);
                    7:     m_cr_left[ch] = d[0] ? 2 : 0;
                    10:    m_presc[ch]  = int'(d);
                    11:    m_upd[ch]    = int'(d[0]);
                    12:    m_pwm[ch]    = int'(d[0]);
                    13:    m_fn_sh[ch]  = int'(d);
                    14:    if (d[0]) m_status[ch] = 0;
                    15:    if (d[0]) m_pend[ch] = 1;
                    default: ;
                endcase
            end
            if (pdv[ch]) m_status[ch] = 1;
        end
    endtask

    task automatic check_outputs(input string pfx);
        logic [31:0] e_per, e_c1, e_c2;
        logic [15:0] e_presc, e_fn;
        logic [1:0]  e_en, e_cr, e_upd, e_pwm;
        for (int ch = 0; ch < NCH; ch++) begin
            e_per[ch*16 +: 16] = 16'(m_per_act[ch]);
            e_c1[ch*16 +: 16]  = 16'(m_c1_act[ch]);
            e_c2[ch*16 +: 16]  = 16'(m_c2_act[ch]);
            e_presc[ch*8 +: 8] = 8'(m_presc[ch]);
            e_fn[ch*8 +: 8]    = 8'(m_fn_act[ch]);
            e_en[ch]  = (m_en[ch] != 0);
            e_cr[ch]  = (m_cr_left[ch] > 0);
            e_upd[ch] = (m_upd[ch] != 0);
            e_pwm[ch] = (m_pwm[ch] != 0);
        end
        chk({pfx, "period"}, per, e_per);
        chk({pfx, "compare1"}, c1, e_c1);
        chk({pfx, "compare2"}, c2, e_c2);
        chk({pfx, "prescale"}, 32'(presc), 32'(e_presc));
        chk({pfx, "functions"}, 32'(fn), 32'(e_fn));
        chk({pfx, "en"}, 32'(en), 32'(e_en));
        chk({pfx, "count_reset"}, 32'(cr), 32'(e_cr));
        chk({pfx, "upnotdown"}, 32'(upd), 32'(e_upd));
        chk({pfx, "pwm_en"}, 32'(pwe), 32'(e_pwm));
    endtask

    // One bus cycle: check the combinational read, clock, then check registered outputs
    task automatic cyc(input logic r, input logic w, input logic [5:0] a, input logic [7:0] d,
                       input logic [1:0] pdv, input logic [31:0] cvv);
        rd = r; wr = w; addr = a; wd = d; pd = pdv; cv = cvv;
        #1;
        last_rd = drd;
        chk("data_read", 32'(drd), 32'(model_read(r, a, cvv)));
        @(posedge clk);
        model_step(r, w, a, d, pdv, cvv);
        #1;
        check_outputs("");
    endtask

    task automatic do_reset();
        rd = 1'b0; wr = 1'b0; pd = '0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic cyc8(input logic r, input logic w, input logic [5:0] a, input logic [7:0] d);
        rd8 = r; wr8 = w; addr8 = a; wd8 = d;
        #1;
        last_rd8 = drd8;
        @(posedge clk);
        #1;
        rd8 = 1'b0; wr8 = 1'b0;
    endtask

    initial begin
        int hi;
        rst_n = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = '0; wd = '0; pd = '0; cv = '0;
        rd8 = 1'b0; wr8 = 1'b0; addr8 = '0; wd8 = '0; pd8 = '0; cv8 = 16'hABCD;
        model_reset();
        #12;
        check_outputs("rst_");
        chk("rst8_outs", {per8, c18}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ch1 period commits only on its period_done pulse while enabled
        cyc(0, 1, 6'h12, 8'h01, 2'b00, 0);
        cyc(0, 1, 6'h10, 8'h34, 2'b00, 0);
        cyc(0, 1, 6'h11, 8'h12, 2'b00, 0);
        cyc(0, 1, 6'h1F, 8'h01, 2'b00, 0);
        repeat (3) begin
            cyc(0, 0, 6'h00, 8'h00, 2'b00, 0);
            chk("r031_hold", 32'(per[31:16]), 32'h0);
        end
        cyc(0, 0, 6'h00, 8'h00, 2'b10, 0);
        chk("r031_xfer", 32'(per[31:16]), 32'h1234);

        // ch0 disabled: commit transfers one cycle after the commit edge
        cyc(0, 1, 6'h03, 8'hAA, 2'b00, 0);
        cyc(0, 1, 6'h04, 8'h00, 2'b00, 0);
        cyc(0, 1, 6'h0F, 8'h01, 2'b00, 0);
        chk("r032_pre", 32'(c1[15:0]), 32'h0);
        cyc(1, 0, 6'h0F, 8'h00, 2'b00, 0);
        chk("r032_pend_set", 32'(last_rd), 32'h1);
        chk("r032_act", 32'(c1[15:0]), 32'h00AA);
        cyc(1, 0, 6'h0F, 8'h00, 2'b00, 0);
        chk("r032_pend_clr", 32'(last_rd), 32'h0);

        // count_reset pulse width, single write then back-to-back writes
        hi = 0;
        cyc(0, 1, 6'h07, 8'h01, 2'b00, 0);
        if (cr[0]) hi++;
        repeat (4) begin cyc(0, 0, 6'h00, 8'h00, 2'b00, 0); if (cr[0]) hi++; end
        chk("r033_single", 32'(hi), 32'd2);
        hi = 0;
        cyc(0, 1, 6'h07, 8'h01, 2'b00, 0);
        if (cr[0]) hi++;
        cyc(0, 1, 6'h07, 8'h01, 2'b00, 0);
        if (cr[0]) hi++;
        repeat (4) begin cyc(0, 0, 6'h00, 8'h00, 2'b00, 0); if (cr[0]) hi++; end
        chk("r033_restart", 32'(hi), 32'd3);

        // counter snapshot: hi byte frozen at the lo read
        cyc(1, 0, 6'h08, 8'h00, 2'b00, 32'h0000_01FF);
        chk("r034_lo", 32'(last_rd), 32'hFF);
        cyc(1, 0, 6'h09, 8'h00, 2'b00, 32'h0000_0200);
        chk("r034_hi", 32'(last_rd), 32'h01);

        // status: set beats simultaneous clear
        cyc(0, 1, 6'h0E, 8'h01, 2'b01, 0);
        cyc(1, 0, 6'h0E, 8'h00, 2'b00, 0);
        chk("r035_set", 32'(last_rd), 32'h01);
        cyc(0, 1, 6'h0E, 8'h01, 2'b00, 0);
        cyc(1, 0, 6'h0E, 8'h00, 2'b00, 0);
        chk("r035_clr", 32'(last_rd), 32'h00);

        // out-of-range channel and count_reset read-back
        cyc(0, 1, 6'h2A, 8'h55, 2'b00, 0);
        cyc(1, 0, 6'h2A, 8'h00, 2'b00, 0);
        chk("oor_read", 32'(last_rd), 32'h0);
        cyc(0, 1, 6'h07, 8'h01, 2'b00, 0);
        cyc(1, 0, 6'h07, 8'h00, 2'b00, 0);
        chk("cnt_rst_read", 32'(last_rd), 32'h0);

        // reset aborts pending commit and count_reset pulse
        cyc(0, 1, 6'h02, 8'h01, 2'b00, 0);
        cyc(0, 1, 6'h00, 8'h77, 2'b00, 0);
        cyc(0, 1, 6'h0F, 8'h01, 2'b00, 0);
        cyc(0, 1, 6'h07, 8'h01, 2'b00, 0);
        do_reset();
        cyc(0, 0, 6'h00, 8'h00, 2'b01, 0);
        chk("r028_no_xfer", 32'(per[15:0]), 32'h0);
        chk("r028_no_cr", 32'(cr), 32'h0);

        // narrow counter instance: hi bytes and missing channels are inert
        cyc8(0, 1, 6'h00, 8'h5A);
        cyc8(0, 1, 6'h01, 8'h77);
        cyc8(0, 1, 6'h21, 8'h33);
        cyc8(0, 1, 6'h22, 8'h01);
        cyc8(0, 1, 6'h0F, 8'h01);
        cyc8(0, 0, 6'h00, 8'h00);
        chk("r036_period", 32'(per8), 32'h005A);
        chk("r036_misc", {c18, presc8}, 32'h0);
        chk("r036_en", 32'(en8), 32'h0);
        cyc8(1, 0, 6'h01, 8'h00);
        chk("r036_hi_rd", 32'(last_rd8), 32'h00);
        cyc8(1, 0, 6'h21, 8'h00);
        chk("r036_oor_rd", 32'(last_rd8), 32'h00);
        cyc8(1, 0, 6'h00, 8'h00);
        chk("r036_lo_rd", 32'(last_rd8), 32'h5A);
        cyc8(1, 0, 6'h08, 8'h00);
        chk("r036_cnt_lo", 32'(last_rd8), 32'hCD);
        cyc8(1, 0, 6'h09, 8'h00);
        chk("r036_cnt_hi", 32'(last_rd8), 32'h00);

        // random traffic with occasional asynchronous resets
        for (int i = 0; i < 2000; i++) begin
            if (i % 400 == 399) begin
                do_reset();
            end else begin
                logic [1:0] ch;
                logic [5:0] a;
                logic [1:0] pdv;
                ch  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3))
                                                  : 2'($urandom_range(0, 1));
                a   = {ch, 4'($urandom_range(0, 15))};
                pdv = {1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0)};
                cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), a,
                    8'($urandom), pdv, $urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_regs_mc.md
PWM_REGS_MC -- requirements
Module: pwm_regs_mc

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 2, meaning number of PWM channels (legal 1..4).
REQ-002 The module SHALL have parameter CNT_W, default 16, meaning counter/period/compare width (legal 8 or 16).
REQ-003 The module SHALL have port clk  input  1  peripheral clock, all state on rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port read  input  1  decoder read strobe.
REQ-006 The module SHALL have port write  input  1  decoder write strobe.
REQ-007 The module SHALL have port addr  input  6  address; addr[5:4] selects channel, addr[3:0] selects offset.
REQ-008 The module SHALL have port data_write  input  8  write byte.
REQ-009 The module SHALL have port data_read  output  8  read byte, combinational from read/addr.
REQ-010 The module SHALL have port counter_val  input  NUM_CH*CNT_W  live counter per channel, channel c at [c*CNT_W +: CNT_W].
REQ-011 The module SHALL have port period_done  input  NUM_CH  one-cycle pulse per channel at counter wrap.
REQ-012 The module SHALL have ports period, compare1, compare2  output  NUM_CH*CNT_W  active values, packed as counter_val.
REQ-013 The module SHALL have ports en, count_reset, upnotdown, pwm_en  output  NUM_CH  per-channel bits.
REQ-014 The module SHALL have ports prescale, functions  output  NUM_CH*8  per-channel bytes.

Function
REQ-015 Per-channel offsets: 0x0/0x1 period lo/hi, 0x2 en, 0x3/0x4 compare1 lo/hi, 0x5/0x6 compare2 lo/hi, 0x7 count_reset, 0x8/0x9 counter lo/hi (RO), 0xA prescale, 0xB upnotdown, 0xC pwm_en, 0xD functions, 0xE status, 0xF commit.
REQ-016 Offsets 0x0,0x1,0x3-0x6,0xD SHALL write shadow registers; reads return shadow value; outputs drive active copies.
REQ-017 Offsets 0x2,0xA,0xB,0xC SHALL write directly to outputs, one cycle write-to-output latency; 1-bit regs use data_write[0], read back zero-extended.
REQ-018 Writing 0xF with bit0=1 SHALL set commit_pending; reading 0xF returns {7'b0, commit_pending}.
REQ-019 With commit_pending=1, active<=shadow and pending clears on the first cycle period_done[c]=1 that follows the pending-setting edge, or on the cycle after setting if en[c]=0.
REQ-020 A commit write coinciding with period_done SHALL defer transfer to the next period_done; a shadow write coinciding with transfer SHALL transfer the old shadow value.
REQ-021 Writing 0x7 with bit0=1 SHALL assert count_reset[c] for exactly 2 cycles starting next edge; re-writing 1 restarts the 2-cycle window; writing 0 deasserts next edge.
REQ-022 Reading 0x8 SHALL return counter_val lo and capture counter hi into a per-channel snapshot on that edge; reading 0x9 returns the snapshot.
REQ-023 Status 0xE bit0 SHALL be sticky-set by period_done[c]; writing 1 to bit0 clears; set SHALL win over simultaneous clear.
REQ-024 With CNT_W=8, hi-byte offsets SHALL ignore writes and read 0x00.
REQ-025 Accesses with addr[5:4]>=NUM_CH, and reads of 0x7, SHALL return 0x00; such writes have no effect.
REQ-026 data_read SHALL be 0x00 whenever read=0; simultaneous read and write SHALL return the pre-write value.

Reset
REQ-027 On rst_n low, all shadow, active, status, snapshot, commit_pending and count_reset state SHALL clear to zero asynchronously; all outputs 0.
REQ-028 Reset asserted mid count_reset pulse or with commit pending SHALL abort both; no transfer after release.

Structure
REQ-029 Offset localparams and legal-parameter limits SHALL live in shared package pwm_regs_pkg.
REQ-030 One per-channel sub-module pwm_ch_regs SHALL hold channel state, instantiated NUM_CH times via generate; top does decode and read mux.

Verification
REQ-031 Write ch1 period 0x1234 via 0x10/0x11, commit, en=1, pulse period_done[1] -> period[31:16] stays 0 until that pulse, then 0x1234.
REQ-032 ch0 en=0, write compare1 0x00AA, commit -> compare1[15:0]=0x00AA one cycle after commit edge, pending reads 0.
REQ-033 Write 0x07=0x01 -> count_reset[0] high exactly 2 cycles; re-write at cycle 2 -> high 3 cycles total.
REQ-034 counter_val ch0=0x01FF, read 0x08, change to 0x0200, read 0x09 -> reads 0xFF then 0x01.
REQ-035 period_done[0] and W1C to 0x0E same cycle -> status reads 0x01; W1C alone next -> 0x00.
REQ-036 NUM_CH=2, CNT_W=8: write 0x21 and 0x01 -> reads 0x00, no output change.
